// File: rtl/axi_read_arbiter_rr.sv
// Round-robin arbiter from N read masters onto one AXI-style read port.
// ARID carries the master index; R beats are steered back by RID.
module axi_read_arbiter_rr #(
   parameter int READ_MASTERS    = 9,
   parameter int ADDR_WIDTH      = 26,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [READ_MASTERS-1:0]                m_arvalid,
   output logic [READ_MASTERS-1:0]                m_arready,
   input  logic [READ_MASTERS*ADDR_WIDTH-1:0]     m_araddr,
   input  logic [READ_MASTERS*4-1:0]              m_arlen,
   output logic [READ_MASTERS-1:0]                m_rvalid,
   input  logic [READ_MASTERS-1:0]                m_rready,
   output logic [READ_MASTERS-1:0]                m_rlast,
   output logic [DATA_WIDTH-1:0]                  m_rdata,
   output logic                                   ARVALID,
   input  logic                                   ARREADY,
   output logic [ID_WIDTH-1:0]                    ARID,
   output logic [3:0]                             ARLEN,
   output logic [ADDR_WIDTH-1:0]                  ARADDR,
   input  logic                                   RVALID,
   output logic                                   RREADY,
   input  logic                                   RLAST,
   input  logic [ID_WIDTH-1:0]                    RID,
   input  logic [DATA_WIDTH-1:0]                  RDATA,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   err_bad_id
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (READ_MASTERS > 1) ? $clog2(READ_MASTERS) : 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t                state;
   logic [PW-1:0]         last_grant;
   logic                  gnt_any;
   logic [PW-1:0]         gnt_idx;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [3:0]            gnt_len;
   logic                  can_grant;
   logic                  rid_ok;
   logic                  ar_hs;
   logic                  r_done;

   // Rotating priority: masters above last_grant first, then wrap to 0.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_addr = '0;
      gnt_len  = '0;
      for (int i = 0; i < READ_MASTERS; i++) begin
         if (!gnt_any && m_arvalid[i] && i > int'(last_grant)) begin
            gnt_any  = 1'b1;
            gnt_idx  = PW'(i);
            gnt_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_len  = m_arlen[i*4 +: 4];
         end
      end
      for (int i = 0; i < READ_MASTERS; i++) begin
         if (!gnt_any && m_arvalid[i] && i <= int'(last_grant)) begin
            gnt_any  = 1'b1;
            gnt_idx  = PW'(i);
            gnt_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_len  = m_arlen[i*4 +: 4];
         end
      end
   end

   assign can_grant = (state == S_IDLE) && (int'(outstanding) < MAX_OUTSTANDING) && gnt_any;

   always_comb begin
      m_arready = '0;
      for (int i = 0; i < READ_MASTERS; i++)
         m_arready[i] = can_grant && (gnt_idx == PW'(i));
   end

   // Out-of-range RIDs are swallowed so a bad slave cannot wedge the R channel.
   always_comb begin
      m_rvalid = '0;
      m_rlast  = '0;
      RREADY   = 1'b1;
      rid_ok   = 1'b0;
      for (int i = 0; i < READ_MASTERS; i++) begin
         if (int'(RID) == i) begin
            rid_ok      = 1'b1;
            m_rvalid[i] = RVALID;
            m_rlast[i]  = RLAST;
            RREADY      = m_rready[i];
         end
      end
   end

   assign m_rdata = RDATA;
   assign ar_hs   = ARVALID && ARREADY;
   assign r_done  = RVALID && RREADY && RLAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ARVALID     <= 1'b0;
         ARID        <= '0;
         ARLEN       <= '0;
         ARADDR      <= '0;
         last_grant  <= PW'(READ_MASTERS - 1);
         outstanding <= '0;
         err_bad_id  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (can_grant) begin
               ARADDR     <= gnt_addr;
               ARLEN      <= gnt_len;
               ARID       <= ID_WIDTH'(gnt_idx);
               last_grant <= gnt_idx;
               ARVALID    <= 1'b1;
               state      <= S_ISSUE;
            end
            S_ISSUE: if (ARREADY) begin
               ARVALID <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (ar_hs && !r_done)
            outstanding <= outstanding + OW'(1);
         else if (r_done && !ar_hs && outstanding != '0)
            outstanding <= outstanding - OW'(1);

         if ((RVALID && !rid_ok) || (r_done && outstanding == '0))
            err_bad_id <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Bench for axi_read_arbiter_rr: directed scenarios, then a random phase
// scored against a queue-based round-robin / routing model.
module tb_axi_read_arbiter_rr;
   localparam int N = 9, AW = 26, DW = 32, IW = 4, MO = 4, OW = $clog2(MO + 1);

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [N*AW-1:0] m_araddr;
   logic [N*4-1:0]  m_arlen;
   logic [DW-1:0]   m_rdata, RDATA;
   logic            ARVALID, ARREADY, RVALID, RREADY, RLAST;
   logic [IW-1:0]   ARID, RID;
   logic [3:0]      ARLEN;
   logic [AW-1:0]   ARADDR;
   logic [OW-1:0]   outstanding;
   logic            err_bad_id;

   axi_read_arbiter_rr #(.READ_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst(rst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_rvalid(m_rvalid),
      .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
      .ARADDR(ARADDR), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
      .RID(RID), .RDATA(RDATA), .outstanding(outstanding), .err_bad_id(err_bad_id));

   always #5 clk = ~clk;

   typedef struct { int id; logic [AW-1:0] addr; logic [3:0] len; } ar_t;
   typedef struct { int id; logic [DW-1:0] data; logic last; } rb_t;
   typedef struct { int id; int left; } burst_t;

   ar_t    exp_ar[$];
   rb_t    exp_r[$];
   burst_t bq[$];
   int     got[$];
   int     n_chk = 0, n_pass = 0;
   bit     rand_on = 0;
   int     model_out = 0;
   ar_t    mon_ar;
   rb_t    mon_r;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) if (m_arready[i]) got.push_back(i);
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin step(); drv(); end
   endtask

   task automatic do_reset();
      m_arvalid = '0; m_rready = '0; ARREADY = 1'b0;
      RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;
      rst = 1'b1;
      drv();
      rst = 1'b0;
      got.delete();
   endtask

   task automatic issue_one(input int idx);
      bit found;
      found = 0;
      m_arvalid[idx] = 1'b1;
      m_araddr[idx*AW +: AW] = AW'($urandom);
      m_arlen[idx*4 +: 4] = 4'(idx);
      for (int c = 0; c < 10 && !found; c++) begin
         step();
         if (m_arready[idx]) found = 1;
         drv();
      end
      chk($sformatf("grant_m%0d", idx), 64'(found), 1);
      m_arvalid[idx] = 1'b0;
   endtask

   // Scoreboard: AR order, R routing and in-flight count from bus handshakes.
   always @(negedge clk) if (rand_on) begin
      chk("outstanding", 64'(outstanding), 64'(model_out));
      if (model_out >= MO) chk("gate_at_max", 64'(m_arready), 0);
      chk("rvalid_onehot", 64'($countones(m_rvalid) <= 1), 1);
      if (ARVALID && ARREADY) begin
         if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
         else begin
            mon_ar = exp_ar.pop_front();
            chk("ar_id", 64'(ARID), 64'(mon_ar.id));
            chk("ar_addr", 64'(ARADDR), 64'(mon_ar.addr));
            chk("ar_len", 64'(ARLEN), 64'(mon_ar.len));
         end
      end
      for (int i = 0; i < N; i++) if (m_rvalid[i] && m_rready[i]) begin
         if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
         else begin
            mon_r = exp_r.pop_front();
            chk("r_dest", 64'(i), 64'(mon_r.id));
            chk("r_data", 64'(m_rdata), 64'(mon_r.data));
            chk("r_last", 64'(m_rlast[i]), 64'(mon_r.last));
         end
      end
      if (ARVALID && ARREADY) model_out++;
      if (RVALID && RREADY && RLAST) model_out--;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: got hang, expected finish");
      $fatal(1);
   end

   initial begin
      int exp_order[6] = '{0, 2, 8, 0, 2, 8};
      logic [DW-1:0] d;
      int cnt[N], nxt[N], tk[N];
      logic [AW-1:0] ra[N][6];
      logic [3:0] rl[N][6];
      int m, ptr, total, cyc, cur, k;
      bit fnd, done, s_ar, s_rhs;
      logic [IW-1:0] s_id;
      logic [3:0] s_len;
      logic [N-1:0] s_mhs;
      ar_t e_ar;
      rb_t er;
      burst_t bt;

      m_araddr = '0; m_arlen = '0;
      rst = 1'b1;
      do_reset();
      drv();
      step();
      chk("rst_arvalid", 64'(ARVALID), 0);
      chk("rst_out", 64'(outstanding), 0);
      chk("rst_err", 64'(err_bad_id), 0);
      chk("rst_arid", 64'(ARID), 0);
      chk("rst_araddr", 64'(ARADDR), 0);
      chk("rst_arlen", 64'(ARLEN), 0);
      drv();

      // single request, latency check
      ARREADY = 1'b1;
      m_arvalid[3] = 1'b1; m_araddr[3*AW +: AW] = 26'h0001040; m_arlen[12 +: 4] = 4'd3;
      step(); chk("t1_arready", 64'(m_arready), 64'h008);
      drv(); m_arvalid[3] = 1'b0;
      step();
      chk("t1_arvalid", 64'(ARVALID), 1);
      chk("t1_arid", 64'(ARID), 3);
      chk("t1_araddr", 64'(ARADDR), 64'h0001040);
      chk("t1_arlen", 64'(ARLEN), 3);
      drv();
      step(); chk("t1_out", 64'(outstanding), 1); chk("t1_arvalid_lo", 64'(ARVALID), 0);
      drv();
      RVALID = 1'b1; RID = 4'd3; RLAST = 1'b1; m_rready = '1;
      step(); chk("t1_rvalid", 64'(m_rvalid), 64'h008); chk("t1_rready", 64'(RREADY), 1);
      drv(); RVALID = 1'b0; RLAST = 1'b0; m_rready = '0;
      step(); chk("t1_out0", 64'(outstanding), 0);
      drv();

      // round-robin order and outstanding cap
      do_reset();
      for (int i = 0; i < N; i++) begin
         m_araddr[i*AW +: AW] = AW'(i * 256);
         m_arlen[i*4 +: 4] = 4'(i);
      end
      m_arvalid = 9'b1_0000_0101; ARREADY = 1'b1;
      run(12);
      step();
      chk("cap_grants", 64'(got.size()), 4);
      chk("cap_out", 64'(outstanding), 4);
      chk("cap_arready", 64'(m_arready), 0);
      drv();
      RVALID = 1'b1; RID = 4'd2; RLAST = 1'b1; m_rready = '1;
      step();
      drv(); RVALID = 1'b0; RLAST = 1'b0;
      step();
      chk("cap_out3", 64'(outstanding), 3);
      chk("cap_regrant", 64'(m_arready), 64'h004);
      drv();
      run(6);
      step(); chk("cap_out4", 64'(outstanding), 4); chk("cap_grants5", 64'(got.size()), 5);
      drv();
      RVALID = 1'b1; RID = 4'd8; RLAST = 1'b1;
      step();
      drv(); RVALID = 1'b0; RLAST = 1'b0;
      run(6);
      chk("rr_grants", 64'(got.size()), 6);
      for (int g = 0; g < 6; g++) chk($sformatf("rr_order%0d", g), 64'(got[g]), 64'(exp_order[g]));

      // interleaved R beats with a stalled master
      do_reset();
      ARREADY = 1'b1;
      m_arvalid = 9'b1_0000_0010;
      step(); chk("il_g1", 64'(m_arready), 64'h002);
      drv(); m_arvalid[1] = 1'b0;
      step(); drv();
      step(); chk("il_g8", 64'(m_arready), 64'h100);
      drv(); m_arvalid[8] = 1'b0;
      run(3);
      step(); chk("il_out2", 64'(outstanding), 2);
      drv();
      m_rready = '1; m_rready[8] = 1'b0;
      d = $urandom; RVALID = 1'b1; RID = 4'd1; RLAST = 1'b0; RDATA = d;
      step();
      chk("il_b1_vld", 64'(m_rvalid), 64'h002); chk("il_b1_data", 64'(m_rdata), 64'(d));
      chk("il_b1_rdy", 64'(RREADY), 1); chk("il_b1_last", 64'(m_rlast), 0);
      drv(); RID = 4'd8; RLAST = 1'b1; RDATA = $urandom;
      step(); chk("il_b8_vld", 64'(m_rvalid), 64'h100); chk("il_b8_rdy", 64'(RREADY), 0);
      drv();
      step(); chk("il_b8_hold", 64'(m_rvalid), 64'h100); chk("il_b8_out", 64'(outstanding), 2);
      drv(); d = $urandom; RID = 4'd1; RLAST = 1'b1; RDATA = d;
      step();
      chk("il_b1l_vld", 64'(m_rvalid), 64'h002); chk("il_b1l_last", 64'(m_rlast), 64'h002);
      chk("il_b1l_data", 64'(m_rdata), 64'(d)); chk("il_b1l_out", 64'(outstanding), 2);
      drv(); RVALID = 1'b0; RLAST = 1'b0;
      step(); chk("il_out1", 64'(outstanding), 1);
      drv();

      // out-of-range RID
      RVALID = 1'b1; RID = 4'd12; RLAST = 1'b0; RDATA = $urandom; m_rready = '0;
      step();
      chk("bad_rready", 64'(RREADY), 1); chk("bad_rvalid", 64'(m_rvalid), 0);
      chk("bad_err_pre", 64'(err_bad_id), 0);
      drv(); RVALID = 1'b0;
      step(); chk("bad_err", 64'(err_bad_id), 1);
      drv(); run(3);
      step(); chk("bad_err_sticky", 64'(err_bad_id), 1);
      drv();
      do_reset();
      step(); chk("bad_err_clr", 64'(err_bad_id), 0);
      drv();

      // simultaneous AR and RLAST handshakes, then reset during ISSUE
      ARREADY = 1'b1;
      issue_one(4);
      issue_one(5);
      run(2);
      step(); chk("sc_out2", 64'(outstanding), 2);
      drv();
      ARREADY = 1'b0;
      issue_one(6);
      ARREADY = 1'b1; RVALID = 1'b1; RID = 4'd4; RLAST = 1'b1; m_rready = '1;
      step(); chk("sc_arvalid", 64'(ARVALID), 1); chk("sc_out_pre", 64'(outstanding), 2);
      drv(); RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b0;
      step(); chk("sc_out", 64'(outstanding), 2);
      drv();
      issue_one(7);
      step(); chk("mr_arvalid", 64'(ARVALID), 1);
      drv();
      rst = 1'b1;
      drv();
      rst = 1'b0;
      step(); chk("mr_arvalid_lo", 64'(ARVALID), 0); chk("mr_out0", 64'(outstanding), 0);
      drv();

      // random phase: per-master request lists, RR order precomputed
      do_reset();
      exp_ar.delete(); exp_r.delete(); bq.delete();
      total = 0;
      for (int i = 0; i < N; i++) begin
         cnt[i] = $urandom_range(0, 5); nxt[i] = 0; tk[i] = 0; total += cnt[i];
         for (int j = 0; j < 6; j++) begin
            ra[i][j] = AW'($urandom); rl[i][j] = 4'($urandom_range(0, 3));
         end
      end
      ptr = N - 1;
      for (int g = 0; g < total; g++) begin
         fnd = 0;
         for (int kk = 1; kk <= N; kk++) begin
            m = (ptr + kk) % N;
            if (!fnd && tk[m] < cnt[m]) begin
               fnd = 1;
               e_ar.id = m; e_ar.addr = ra[m][tk[m]]; e_ar.len = rl[m][tk[m]];
               exp_ar.push_back(e_ar);
               tk[m]++; ptr = m;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         m_arvalid[i] = (cnt[i] > 0);
         m_araddr[i*AW +: AW] = ra[i][0];
         m_arlen[i*4 +: 4] = rl[i][0];
      end
      model_out = 0; rand_on = 1; cyc = 0; cur = -1; done = 0;
      while (cyc < 3000 && !done) begin
         @(negedge clk);
         s_ar = ARVALID && ARREADY; s_id = ARID; s_len = ARLEN;
         s_mhs = m_arready & m_arvalid;
         s_rhs = RVALID && RREADY;
         drv();
         for (int i = 0; i < N; i++) if (s_mhs[i]) begin
            nxt[i]++;
            m_arvalid[i] = (nxt[i] < cnt[i]);
            if (nxt[i] < cnt[i]) begin
               m_araddr[i*AW +: AW] = ra[i][nxt[i]];
               m_arlen[i*4 +: 4] = rl[i][nxt[i]];
            end
         end
         if (s_ar) begin bt.id = int'(s_id); bt.left = int'(s_len) + 1; bq.push_back(bt); end
         ARREADY = ($urandom_range(0, 3) != 0);
         if (s_rhs) begin
            bq[cur].left--;
            if (bq[cur].left == 0) bq.delete(cur);
            cur = -1; RVALID = 1'b0; RLAST = 1'b0;
         end
         if (cur < 0 && bq.size() > 0 && $urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, bq.size() - 1);
            cur = k;
            for (int j = bq.size() - 1; j >= 0; j--) if (bq[j].id == bq[k].id) cur = j;
            RVALID = 1'b1; RID = IW'(bq[cur].id); RDATA = $urandom; RLAST = (bq[cur].left == 1);
            er.id = bq[cur].id; er.data = RDATA; er.last = RLAST;
            exp_r.push_back(er);
         end
         m_rready = N'($urandom);
         cyc++;
         done = (exp_ar.size() == 0) && (bq.size() == 0) && !RVALID;
         for (int i = 0; i < N; i++) if (nxt[i] < cnt[i]) done = 0;
      end
      chk("rand_done", 64'(done), 1);
      step(); drv();
      rand_on = 0;
      chk("rand_r_left", 64'(exp_r.size()), 0);
      step(); chk("rand_out0", 64'(outstanding), 0);
      drv();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
